// File: rtl/memory_access_if.sv
// Execute-to-MEM instruction handshake and the MEM-to-write-back result bundle.
interface memory_access_if;
  logic        valid_in;
  logic [31:0] alu_result_in;
  logic [31:0] store_data_in;
  logic [4:0]  rd_in;
  logic        reg_write_in;
  logic        mem_to_reg_in;
  logic        mem_read;
  logic        mem_write;
  logic [1:0]  mem_size;
  logic        mem_unsigned;
  logic        stall;
  logic        valid_out;
  logic [31:0] alu_data_out;
  logic [31:0] dm_data_out;
  logic [4:0]  rd_out;
  logic        reg_write_out;
  logic        mem_to_reg_out;
  logic        misaligned;

  modport master (
    output valid_in, alu_result_in, store_data_in, rd_in, reg_write_in,
           mem_to_reg_in, mem_read, mem_write, mem_size, mem_unsigned,
    input  stall, valid_out, alu_data_out, dm_data_out, rd_out,
           reg_write_out, mem_to_reg_out, misaligned
  );

  modport slave (
    input  valid_in, alu_result_in, store_data_in, rd_in, reg_write_in,
           mem_to_reg_in, mem_read, mem_write, mem_size, mem_unsigned,
    output stall, valid_out, alu_data_out, dm_data_out, rd_out,
           reg_write_out, mem_to_reg_out, misaligned
  );
endinterface

// File: rtl/memory_access.sv
// MEM pipeline stage: byte/half/word loads and stores against a local data
// memory with a fixed multi-cycle access latency, stalling upstream while busy.
module memory_access #(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 2
) (
  input  logic           clk,
  input  logic           reset,
  memory_access_if.slave bus
);
  localparam int AW    = $clog2(DEPTH_WORDS);
  localparam int CNT_W = $clog2(LATENCY + 1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t           state, state_next;
  logic [CNT_W-1:0] cnt;
  logic [31:0]      mem [DEPTH_WORDS];

  logic [31:0] addr_p0, data_p0;
  logic [4:0]  rd_p0;
  logic        rw_p0, m2r_p0, ld_p0, st_p0, uns_p0;
  logic [1:0]  size_p0;

  logic [31:0] addr, data;
  logic [4:0]  rd;
  logic        rw, m2r, ld, st, uns;
  logic [1:0]  size;

  logic          is_mem, is_load, mis, accept, fast, go_busy, complete, we;
  logic [AW-1:0] idx;
  logic [31:0]   word, load_val;

  logic        vld_p1, rw_p1, m2r_p1, mis_p1;
  logic [31:0] alu_p1, dm_p1;
  logic [4:0]  rd_p1;

  function automatic logic [31:0] merge_store(input logic [31:0] old,
                                              input logic [31:0] wdata,
                                              input logic [1:0]  sz,
                                              input logic [1:0]  lane);
    logic [31:0] w;
    w = old;
    case (sz)
      2'b00:   w[{lane, 3'b000} +: 8]     = wdata[7:0];
      2'b01:   w[{lane[1], 4'b0000} +: 16] = wdata[15:0];
      default: w = wdata;
    endcase
    return w;
  endfunction

  function automatic logic [31:0] extend_load(input logic [31:0] w,
                                              input logic [1:0]  sz,
                                              input logic [1:0]  lane,
                                              input logic        zext);
    logic signed [7:0]  b;
    logic signed [15:0] h;
    logic signed [31:0] r;
    b = w[{lane, 3'b000} +: 8];
    h = w[{lane[1], 4'b0000} +: 16];
    case (sz)
      2'b00:   r = zext ? $signed({24'b0, b}) : 32'(b);
      2'b01:   r = zext ? $signed({16'b0, h}) : 32'(h);
      default: r = w;
    endcase
    return r;
  endfunction

  // In IDLE the live inputs are the operation; in BUSY the captured copy is.
  always_comb begin
    if (state == IDLE) begin
      addr = bus.alu_result_in;
      data = bus.store_data_in;
      rd   = bus.rd_in;
      rw   = bus.reg_write_in;
      m2r  = bus.mem_to_reg_in;
      ld   = bus.mem_read;
      st   = bus.mem_write;
      size = bus.mem_size;
      uns  = bus.mem_unsigned;
    end else begin
      addr = addr_p0;
      data = data_p0;
      rd   = rd_p0;
      rw   = rw_p0;
      m2r  = m2r_p0;
      ld   = ld_p0;
      st   = st_p0;
      size = size_p0;
      uns  = uns_p0;
    end
  end

  assign is_mem   = ld | st;
  assign is_load  = ld & ~st;
  assign mis      = is_mem & (((size == 2'b01) & addr[0]) |
                              (size[1] & (addr[1:0] != 2'b00)));
  assign idx      = addr[AW+1:2];
  assign word     = mem[idx];
  assign load_val = extend_load(word, size, addr[1:0], uns);
  assign accept   = (state == IDLE) & bus.valid_in;
  assign fast     = ~is_mem | mis | (LATENCY == 1);
  assign go_busy  = accept & ~fast;
  assign complete = (accept & fast) | ((state == BUSY) & (cnt == CNT_W'(1)));
  // Reset gating keeps an aborted or reset-time store from ever committing.
  assign we       = complete & st & ~mis & reset;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      if (go_busy)
        cnt <= CNT_W'(LATENCY - 1);
      else if (state == BUSY)
        cnt <= cnt - CNT_W'(1);
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (go_busy) state_next = BUSY;
      BUSY:    if (cnt == CNT_W'(1)) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // p0: operand capture at acceptance
  always_ff @(posedge clk) begin
    if (accept) begin
      addr_p0 <= bus.alu_result_in;
      data_p0 <= bus.store_data_in;
      rd_p0   <= bus.rd_in;
      rw_p0   <= bus.reg_write_in;
      m2r_p0  <= bus.mem_to_reg_in;
      ld_p0   <= bus.mem_read;
      st_p0   <= bus.mem_write;
      size_p0 <= bus.mem_size;
      uns_p0  <= bus.mem_unsigned;
    end
  end

  always_ff @(posedge clk) begin
    if (we)
      mem[idx] <= merge_store(word, data, size, addr[1:0]);
  end

  // p1: registered results toward write-back
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vld_p1 <= 1'b0;
      alu_p1 <= '0;
      dm_p1  <= '0;
      rd_p1  <= '0;
      rw_p1  <= 1'b0;
      m2r_p1 <= 1'b0;
      mis_p1 <= 1'b0;
    end else if (complete) begin
      vld_p1 <= 1'b1;
      alu_p1 <= addr;
      dm_p1  <= (is_load & ~mis) ? load_val : 32'h0;
      rd_p1  <= rd;
      rw_p1  <= rw & ~mis;
      m2r_p1 <= m2r;
      mis_p1 <= mis;
    end else begin
      vld_p1 <= 1'b0;
      rw_p1  <= 1'b0;
      mis_p1 <= 1'b0;
    end
  end

  assign bus.stall          = (state == BUSY);
  assign bus.valid_out      = vld_p1;
  assign bus.alu_data_out   = alu_p1;
  assign bus.dm_data_out    = dm_p1;
  assign bus.rd_out         = rd_p1;
  assign bus.reg_write_out  = rw_p1;
  assign bus.mem_to_reg_out = m2r_p1;
  assign bus.misaligned     = mis_p1;
endmodule
